// File: rtl/ifetch_control.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_control
// Brief    : Instruction fetch sequencer. Drives the external PC register,
//            issues single outstanding instruction-memory reads and presents
//            fetched words to decode with a valid/ready handshake. Branch
//            redirects from execute take priority over sequential flow.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_control #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h00000064
) (
  input  logic             clk,
  input  logic             rst_n,
  // PC register interface
  input  logic [WIDTH-1:0] pc_in,
  output logic             pc_load,
  output logic [WIDTH-1:0] pc_next,
  // redirect from execute
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_target,
  // instruction memory
  output logic             imem_read,
  output logic [WIDTH-1:0] imem_address,
  input  logic             imem_resp,
  input  logic [WIDTH-1:0] imem_rdata,
  // decode interface
  output logic             ir_valid,
  output logic [WIDTH-1:0] ir_data,
  output logic [WIDTH-1:0] ir_pc,
  input  logic             ir_ready
);

  // START : load the reset vector into the PC register
  // STEP  : one settle cycle after any PC load
  // FETCH : memory read outstanding
  // HOLD  : instruction presented to decode, waiting for acceptance
  localparam logic [1:0] ST_START = 2'd0;
  localparam logic [1:0] ST_STEP  = 2'd1;
  localparam logic [1:0] ST_FETCH = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // Instructions are word aligned; the two LSBs of any loaded PC are cleared.
  localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};
  localparam logic [WIDTH-1:0] INSN_BYTES = WIDTH'(4);

  logic [1:0]       state;
  logic [1:0]       state_nxt;

  // Redirect that arrived while a read was outstanding; applied on response.
  logic             pend_valid;
  logic [WIDTH-1:0] pend_target;

  // Control strobes produced by the next-state logic
  logic             pend_set;
  logic             pend_clr;
  logic             capture;
  logic             drop;
  logic             fire;
  logic [WIDTH-1:0] load_raw;

  // Decode accepts the held instruction only when no redirect is present.
  assign fire = ir_valid & ir_ready & ~redirect;

  // Memory address always tracks the PC register; it only matters while
  // imem_read is high, and the PC cannot change mid-request.
  assign imem_address = pc_in;

  // Alignment is applied once here so every load source is covered.
  assign pc_next = load_raw & ALIGN_MASK;

  // Next-state and combinational PC/memory control
  always_comb begin
    state_nxt = state;
    pc_load   = 1'b0;
    load_raw  = pc_in + INSN_BYTES;
    imem_read = 1'b0;
    pend_set  = 1'b0;
    pend_clr  = 1'b0;
    capture   = 1'b0;
    drop      = 1'b0;
    if (rst_n) begin
      case (state)
        ST_START: begin
          pc_load   = 1'b1;
          load_raw  = RESET_PC;
          state_nxt = ST_STEP;
        end
        ST_STEP: begin
          if (redirect) begin
            // Reload and settle again before fetching from the new target.
            pc_load  = 1'b1;
            load_raw = redirect_target;
          end else begin
            state_nxt = ST_FETCH;
          end
        end
        ST_FETCH: begin
          // The request stays asserted until the memory answers.
          imem_read = 1'b1;
          if (imem_resp) begin
            if (redirect || pend_valid) begin
              // Fetched word belongs to the wrong path: discard it.
              pc_load   = 1'b1;
              load_raw  = redirect ? redirect_target : pend_target;
              pend_clr  = 1'b1;
              state_nxt = ST_STEP;
            end else begin
              capture   = 1'b1;
              state_nxt = ST_HOLD;
            end
          end else if (redirect) begin
            pend_set = 1'b1;
          end
        end
        ST_HOLD: begin
          if (redirect) begin
            // Redirect beats a simultaneous ready; the held word is dropped.
            pc_load   = 1'b1;
            load_raw  = redirect_target;
            drop      = 1'b1;
            state_nxt = ST_STEP;
          end else if (fire) begin
            pc_load   = 1'b1;
            load_raw  = pc_in + INSN_BYTES;
            drop      = 1'b1;
            state_nxt = ST_STEP;
          end
        end
        default: begin
          state_nxt = ST_START;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_START;
    end else begin
      state <= state_nxt;
    end
  end

  // Pending redirect capture; a later redirect overwrites an earlier one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else if (pend_set) begin
      pend_valid  <= 1'b1;
      pend_target <= redirect_target;
    end else if (pend_clr) begin
      pend_valid  <= 1'b0;
    end
  end

  // Instruction register presented to decode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir_valid <= 1'b0;
      ir_data  <= '0;
      ir_pc    <= '0;
    end else if (capture) begin
      ir_valid <= 1'b1;
      ir_data  <= imem_rdata;
      ir_pc    <= pc_in;
    end else if (drop) begin
      ir_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/ifetch_control.md
IFETCH_CONTROL -- requirements
Module: ifetch_control

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of PC, address and instruction.
REQ-002 Parameter RESET_PC, default 32'h00000064, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 pc_in  input  WIDTH  current PC from the PC register.
REQ-006 pc_load  output  1  load strobe to the PC register.
REQ-007 pc_next  output  WIDTH  value to load into the PC register.
REQ-008 redirect  input  1  branch/jump redirect request from execute.
REQ-009 redirect_target  input  WIDTH  redirect destination.
REQ-010 imem_read  output  1  instruction memory read request.
REQ-011 imem_address  output  WIDTH  instruction memory address.
REQ-012 imem_resp  input  1  memory response; imem_rdata valid this cycle.
REQ-013 imem_rdata  input  WIDTH  instruction word.
REQ-014 ir_valid  output  1  fetched instruction valid to decode.
REQ-015 ir_data  output  WIDTH  fetched instruction.
REQ-016 ir_pc  output  WIDTH  PC of fetched instruction.
REQ-017 ir_ready  input  1  decode accepts instruction.

Function
REQ-018 FSM states START, STEP, FETCH, HOLD.
REQ-019 START: pc_load=1, pc_next=RESET_PC; next state STEP.
REQ-020 STEP: imem_read=0, one-cycle settle after any pc_load; next state FETCH, unless redirect=1 (then pc_load=1, pc_next=target, stay STEP).
REQ-021 FETCH: imem_read=1, imem_address=pc_in; imem_read held high until imem_resp=1, never withdrawn mid-request.
REQ-022 FETCH, imem_resp=1, no redirect pending: register ir_data=imem_rdata, ir_pc=pc_in, ir_valid=1; next state HOLD.
REQ-023 FETCH, redirect=1 before or with imem_resp: latch target into pending register, set pending flag; later redirects overwrite target (last wins).
REQ-024 FETCH, imem_resp=1 with pending flag or redirect=1: discard imem_rdata, ir_valid stays 0, pc_load=1, pc_next=redirect_target if redirect=1 else pending target, clear pending; next state STEP.
REQ-025 HOLD: ir_valid=1, ir_data/ir_pc stable until handshake or redirect.
REQ-026 Handshake fire = ir_valid & ir_ready & ~redirect; on fire pc_load=1, pc_next=pc_in+4, ir_valid cleared next cycle; next state STEP.
REQ-027 HOLD, redirect=1: redirect wins over ir_ready; instruction dropped (ir_valid 0 next cycle), pc_load=1, pc_next=redirect_target; next state STEP.
REQ-028 pc_in+4 wraps modulo 2^WIDTH (32'hFFFFFFFC -> 32'h00000000).
REQ-029 pc_next bits [1:0] forced to 0 for every load source.
REQ-030 pc_load, pc_next, imem_read, imem_address combinational from state and inputs; pc_load=0 whenever not specified above.
REQ-031 Latency: fire in HOLD at cycle t -> pc_load at t, STEP at t+1, imem_read at t+2.

Reset
REQ-032 rst_n=0 at clock edge: state=START, ir_valid=0, ir_data=0, ir_pc=0, pending flag=0, pending target=0.
REQ-033 While rst_n=0: pc_load=0, imem_read=0.
REQ-034 Reset asserted in FETCH abandons the outstanding request; imem_resp arriving in START/STEP is ignored.
REQ-035 First cycle after rst_n rises: pc_load=1, pc_next=32'h00000064.

Verification
REQ-036 Reset release -> pc_load=1/pc_next=0x64, then imem_read=1 with imem_address=0x64 two cycles later.
REQ-037 FETCH 0x64, imem_resp with rdata 0x00000013 after 3 wait cycles, ir_ready=1 -> ir_valid=1, ir_data=0x13, ir_pc=0x64; pc_next=0x68.
REQ-038 ir_ready=0 for 5 cycles in HOLD -> ir_valid, ir_data, ir_pc constant; no pc_load; no imem_read.
REQ-039 redirect to 0x200 during FETCH, resp 2 cycles later -> data discarded, ir_valid stays 0, pc_next=0x200, next imem_address=0x200.
REQ-040 redirect to 0x300 and ir_ready=1 same cycle in HOLD -> no fire, pc_next=0x300, ir_valid=0 next cycle.
REQ-041 pc_in=0xFFFFFFFC accepted -> pc_next=0x00000000; redirect_target 0x203 -> pc_next=0x200.
